// File: rtl/ila_capture_ctrl.sv
// Capture controller for the ILA sample BRAM: masked-pattern trigger, circular pre/post
// capture, and a two-stage write pipeline that matches the BRAM's registered data input.
module ila_capture_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [ADDR_WIDTH-1:0] pre_trig,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr_write,
    output logic [DATA_WIDTH-1:0] mem_di,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   wptr, cnt, pre_q, post_cnt;
    logic [ADDR_WIDTH-1:0]   addr_d1;
    logic                    we_d1;
    logic                    done_d1;
    logic                    match;
    logic                    capturing;
    logic                    start;

    assign match = ((sample_in ^ trig_value) & trig_mask) == '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = (pre_trig == '0) ? S_ARMED : S_PRE;
            S_PRE:          if (cnt + 1'b1 == pre_q) state_next = S_ARMED;
            // Post length is D-1-pre, i.e. the bitwise complement of pre.
            S_ARMED:        if (match) state_next = (~pre_q == '0) ? S_DONE : S_POST;
            S_POST:         if (post_cnt == ADDR_WIDTH'(1)) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    // Output / control decode; busy also covers the writes still draining through the pipeline
    always_comb begin
        capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
        busy      = capturing || we_d1 || mem_we;
        start     = arm && !busy && ((state == S_IDLE) || (state == S_DONE));
        state_dbg = state;
    end

    // Datapath and write pipeline: data leads write-enable/address by one register
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr           <= '0;
            cnt            <= '0;
            pre_q          <= '0;
            post_cnt       <= '0;
            trig_addr      <= '0;
            start_addr     <= '0;
            mem_di         <= '0;
            we_d1          <= 1'b0;
            addr_d1        <= '0;
            mem_we         <= 1'b0;
            mem_addr_write <= '0;
            done_d1        <= 1'b0;
            done           <= 1'b0;
        end else begin
            mem_di         <= sample_in;
            we_d1          <= capturing;
            addr_d1        <= wptr;
            mem_we         <= we_d1;
            mem_addr_write <= addr_d1;
            done_d1        <= (state == S_DONE) && !start;
            done           <= done_d1 && !start;

            if (start) begin
                wptr  <= '0;
                cnt   <= '0;
                pre_q <= pre_trig;
            end else if (capturing) begin
                wptr <= wptr + 1'b1;
            end

            if (state == S_PRE) cnt <= cnt + 1'b1;

            if (state == S_ARMED && match) begin
                trig_addr  <= wptr;
                start_addr <= wptr - pre_q;
                post_cnt   <= ~pre_q;
            end else if (state == S_POST) begin
                post_cnt <= post_cnt - 1'b1;
            end
        end
    end

endmodule
